// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature A/B decoder: Gray state codes,
// step classification and the forward-sequence helper.
package qdec_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    ERR  = 2'd3
  } step_cls_t;

  // Next state in the forward order 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] next_fwd(input logic [1:0] state);
    logic [1:0] nxt;
    case (state)
      S00:     nxt = S01;
      S01:     nxt = S11;
      S11:     nxt = S10;
      default: nxt = S00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/qdec_sync.sv
// Two-bit synchronizer for the A/B lines with an optional stability filter.
// Build option: define QDEC_FILTER_EN to enable the FILTER_LEN-sample filter.
module qdec_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_in,
  input  logic       b_in,
  output logic [1:0] cur
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("qdec_sync: SYNC_STAGES must be at least 2");
  end

  logic [1:0] sync_p [SYNC_STAGES];

  // Metastability chain: stage 0 samples the raw lines, later stages settle them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= 2'b00;
    end else begin
      sync_p[0] <= {a_in, b_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

`ifdef QDEC_FILTER_EN
  if (FILTER_LEN < 2) begin : g_bad_filter
    $error("qdec_sync: FILTER_LEN must be at least 2 when the filter is enabled");
  end

  logic [1:0] hist_p [FILTER_LEN-1];
  logic [1:0] hold_p;
  logic       stable;

  // History of past synchronized samples plus the last accepted value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FILTER_LEN - 1; i++) hist_p[i] <= 2'b00;
      hold_p <= 2'b00;
    end else begin
      hist_p[0] <= sync_p[SYNC_STAGES-1];
      for (int i = 1; i < FILTER_LEN - 1; i++) hist_p[i] <= hist_p[i-1];
      hold_p <= cur;
    end
  end

  // Accept the current sample only once FILTER_LEN consecutive samples agree.
  always_comb begin
    stable = 1'b1;
    for (int i = 0; i < FILTER_LEN - 1; i++) begin
      if (hist_p[i] != sync_p[SYNC_STAGES-1]) stable = 1'b0;
    end
    cur = stable ? sync_p[SYNC_STAGES-1] : hold_p;
  end
`else
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("qdec_sync: FILTER_LEN must be positive");
  end

  assign cur = sync_p[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_ab_decoder.sv
// Receive-side decoder for the 2-bit {A,B} Gray sequence: priming, step
// classification, wrapping position counter, direction and saturating errors.
// Build option: define QDEC_FILTER_EN to add the input stability filter.
module quad_ab_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int ERR_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             step_up,
  output logic             step_dn,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

`ifdef QDEC_FILTER_EN
  localparam int PRIME_N = SYNC_STAGES + FILTER_LEN;
`else
  localparam int PRIME_N = SYNC_STAGES + 1;
`endif
  localparam int PRIME_W = $clog2(PRIME_N + 1);

  logic [1:0]         cur;
  logic [1:0]         prev_p1;
  logic [PRIME_W-1:0] prime_cnt;
  logic               primed;
  step_cls_t          cls;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  qdec_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .a_in (a_in),
    .b_in (b_in),
    .cur  (cur)
  );

  assign primed = (prime_cnt == PRIME_W'(PRIME_N));

  // Classify the change between the previous and current state word.
  always_comb begin
    if (cur == prev_p1)                cls = NONE;
    else if (cur == next_fwd(prev_p1)) cls = UP;
    else if (prev_p1 == next_fwd(cur)) cls = DN;
    else                               cls = ERR;
  end

  // Register pulses and update count/dir/err_cnt; clr overrides the counters only.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_cnt <= '0;
      prev_p1   <= S00;
      count     <= '0;
      err_cnt   <= '0;
      dir       <= 1'b0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev_p1 <= cur;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      err     <= 1'b0;
      if (!primed) begin
        prime_cnt <= prime_cnt + 1'b1;
      end else begin
        case (cls)
          UP: begin
            step_up <= 1'b1;
            count   <= count + 1'b1;
            dir     <= 1'b1;
          end
          DN: begin
            step_dn <= 1'b1;
            count   <= count - 1'b1;
            dir     <= 1'b0;
          end
          ERR: begin
            err     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
          end
          default: ;
        endcase
      end
      if (clr) begin
        count   <= '0;
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quad_ab_decoder.sv
// Self-checking bench for quad_ab_decoder: directed scenarios plus a random
// walk compared against a position-index reference model.
module tb_quad_ab_decoder;

  localparam int SYNC = 2;
`ifdef QDEC_FILTER_EN
  localparam int LAT      = SYNC + 2;
  localparam int MIN_HOLD = 2;
`else
  localparam int LAT      = SYNC + 1;
  localparam int MIN_HOLD = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] count;
  logic       step_up, step_dn, dir, err;
  logic [3:0] err_cnt;

  quad_ab_decoder #(
    .CNT_W(8), .ERR_W(4), .SYNC_STAGES(SYNC), .FILTER_LEN(2)
  ) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .clr(clr),
    .count(count), .step_up(step_up), .step_dn(step_dn), .dir(dir),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [1:0] samp[$];
  logic [7:0] m_count;
  logic [3:0] m_err_cnt;
  logic       m_dir, m_up, m_dn, m_err;

  // Observation tallies
  int seen_up, seen_dn, seen_err, multi, lat, since_drive;

  // Position of a state word along the forward Gray order.
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic clear_tally();
    seen_up = 0; seen_dn = 0; seen_err = 0; multi = 0;
  endtask

  task automatic drive(input logic [1:0] ab);
    {a_in, b_in} = ab;
    since_drive = 0;
    lat = -1;
  endtask

  // Advance one clock, updating the model from the controls seen at that edge.
  task automatic clk_cycle();
    int n, d;
    @(posedge clk);
    if (reset) begin
      samp.delete();
      m_count = '0; m_err_cnt = '0; m_dir = 1'b0;
      m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
    end else begin
      samp.push_back({a_in, b_in});
      n = samp.size();
      m_up = 1'b0; m_dn = 1'b0; m_err = 1'b0;
      if (n > LAT) begin
        d = (gidx(samp[n-LAT]) - gidx(samp[n-LAT-1]) + 4) % 4;
        if (d == 1) begin m_up = 1'b1; m_count = m_count + 8'd1; m_dir = 1'b1; end
        else if (d == 3) begin m_dn = 1'b1; m_count = m_count - 8'd1; m_dir = 1'b0; end
        else if (d == 2) begin
          m_err = 1'b1;
          if (m_err_cnt != 4'hF) m_err_cnt = m_err_cnt + 4'd1;
        end
      end
      if (clr) begin m_count = '0; m_err_cnt = '0; end
    end
    #1;
    since_drive++;
    if (step_up) seen_up++;
    if (step_dn) seen_dn++;
    if (err) seen_err++;
    if ((int'(step_up) + int'(step_dn) + int'(err)) > 1) multi++;
    if ((step_up || step_dn || err) && lat < 0) lat = since_drive;
  endtask

  task automatic hold(input logic [1:0] ab, input int cycles);
    drive(ab);
    repeat (cycles) clk_cycle();
  endtask

  task automatic do_reset(input logic [1:0] ab);
    drive(ab);
    clr = 1'b0;
    reset = 1'b1;
    repeat (2) clk_cycle();
    reset = 1'b0;
    hold(ab, 6);
    clear_tally();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(2'b11);
    clk_cycle();
    n_tests++;
    if ({count, err_cnt, dir, step_up, step_dn, err} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d err_cnt=%0d dir=%b up=%b dn=%b err=%b, want all 0",
               count, err_cnt, dir, step_up, step_dn, err);
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int bad_lat = 0;
    do_reset(2'b00);
    foreach (seq[i]) begin
      hold(seq[i], 4);
      if (lat != LAT) bad_lat++;
    end
    n_tests++;
    if (seen_up !== 4 || seen_dn !== 0 || seen_err !== 0) begin
      n_fail++;
      $display("FAIL fwd_pulses: got up=%0d dn=%0d err=%0d, want 4/0/0", seen_up, seen_dn, seen_err);
    end
    n_tests++;
    if (count !== 8'd4 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_count: got count=%0d dir=%b, want 4/1", count, dir);
    end
    n_tests++;
    if (bad_lat !== 0) begin
      n_fail++;
      $display("FAIL fwd_latency: got %0d steps off latency (last %0d), want 0 (latency %0d)",
               bad_lat, lat, LAT);
    end
  endtask

  task automatic test_backward();
    logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset(2'b00);
    foreach (seq[i]) hold(seq[i], 4);
    n_tests++;
    if (seen_dn !== 4 || seen_up !== 0 || seen_err !== 0) begin
      n_fail++;
      $display("FAIL bwd_pulses: got up=%0d dn=%0d err=%0d, want 0/4/0", seen_up, seen_dn, seen_err);
    end
    n_tests++;
    if (count !== 8'd252 || dir !== 1'b0) begin
      n_fail++;
      $display("FAIL bwd_count: got count=%0d dir=%b, want 252/0", count, dir);
    end
  endtask

  task automatic test_errors();
    do_reset(2'b00);
    hold(2'b11, 4);
    hold(2'b00, 4);
    n_tests++;
    if (seen_err !== 2 || err_cnt !== 4'd2 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL err_two: got err=%0d err_cnt=%0d count=%0d, want 2/2/0", seen_err, err_cnt, count);
    end
    for (int i = 0; i < 20; i++) hold((i % 2 == 0) ? 2'b11 : 2'b00, 4);
    n_tests++;
    if (err_cnt !== 4'hF || seen_err !== 22 || seen_up !== 0 || seen_dn !== 0) begin
      n_fail++;
      $display("FAIL err_sat: got err_cnt=%0d errs=%0d up=%0d dn=%0d, want 15/22/0/0",
               err_cnt, seen_err, seen_up, seen_dn);
    end
  endtask

  task automatic test_prime();
    do_reset(2'b11);
    hold(2'b11, 4);
    n_tests++;
    if (seen_up !== 0 || seen_dn !== 0 || seen_err !== 0) begin
      n_fail++;
      $display("FAIL prime_quiet: got up=%0d dn=%0d err=%0d, want 0/0/0", seen_up, seen_dn, seen_err);
    end
    hold(2'b10, 6);
    n_tests++;
    if (seen_up !== 1 || count !== 8'd1 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL prime_step: got up=%0d count=%0d dir=%b, want 1/1/1", seen_up, count, dir);
    end
  endtask

  task automatic test_clr();
    logic [1:0] seq [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
    do_reset(2'b00);
    hold(2'b11, 4);
    hold(2'b00, 4);
    foreach (seq[i]) hold(seq[i], 4);
    n_tests++;
    if (count !== 8'd7 || err_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL clr_setup: got count=%0d err_cnt=%0d, want 7/2", count, err_cnt);
    end
    drive(2'b00);
    repeat (LAT - 1) clk_cycle();
    clr = 1'b1;
    clk_cycle();
    clr = 1'b0;
    n_tests++;
    if (step_up !== 1'b1 || count !== 8'd0 || err_cnt !== 4'd0 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_prio: got up=%b count=%0d err_cnt=%0d dir=%b, want 1/0/0/1",
               step_up, count, err_cnt, dir);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(2'b00);
    hold(2'b10, 4);
    hold(2'b11, 4);
    hold(2'b00, 1);
    drive(2'b01);
    reset = 1'b1;
    clk_cycle();
    n_tests++;
    if ({count, err_cnt, dir, step_up, step_dn, err} !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got count=%0d err_cnt=%0d dir=%b up=%b dn=%b err=%b, want all 0",
               count, err_cnt, dir, step_up, step_dn, err);
    end
    reset = 1'b0;
    hold(2'b01, 8);
    clear_tally();
    n_tests++;
    if (count !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset_reprime: got count=%0d, want 0", count);
    end
  endtask

  task automatic test_glitch();
    int exp_n;
`ifdef QDEC_FILTER_EN
    exp_n = 0;
`else
    exp_n = 1;
`endif
    do_reset(2'b00);
    hold(2'b01, 1);
    hold(2'b00, 8);
    n_tests++;
    if (seen_up !== exp_n || seen_dn !== exp_n || seen_err !== 0) begin
      n_fail++;
      $display("FAIL glitch: got up=%0d dn=%0d err=%0d, want %0d/%0d/0",
               seen_up, seen_dn, seen_err, exp_n, exp_n);
    end
    clear_tally();
    hold(2'b01, 3);
    hold(2'b01, 4);
    n_tests++;
    if (seen_up !== 1 || count !== 8'd1) begin
      n_fail++;
      $display("FAIL glitch_hold: got up=%0d count=%0d, want 1/1", seen_up, count);
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    int bad = 0;
    int first_bad = -1;
    do_reset(2'b00);
    while (cyc < 600) begin
      drive(2'($urandom_range(0, 3)));
      repeat ($urandom_range(MIN_HOLD, MIN_HOLD + 3)) begin
        clr = ($urandom_range(0, 15) == 0);
        clk_cycle();
        cyc++;
        n_tests++;
        if ({count, err_cnt, dir, step_up, step_dn, err} !==
            {m_count, m_err_cnt, m_dir, m_up, m_dn, m_err}) begin
          n_fail++;
          bad++;
          if (bad <= 5)
            $display("FAIL random_cycle%0d: got count=%0d err_cnt=%0d dir=%b up=%b dn=%b err=%b, want count=%0d err_cnt=%0d dir=%b up=%b dn=%b err=%b",
                     cyc, count, err_cnt, dir, step_up, step_dn, err,
                     m_count, m_err_cnt, m_dir, m_up, m_dn, m_err);
          if (first_bad < 0) first_bad = cyc;
        end
      end
    end
    clr = 1'b0;
    n_tests++;
    if (multi !== 0) begin
      n_fail++;
      $display("FAIL onehot: got %0d cycles with multiple pulses, want 0", multi);
    end
  endtask

  initial begin
    clear_tally();
    lat = -1;
    since_drive = 0;
    test_reset();
    test_forward();
    test_backward();
    test_errors();
    test_prime();
    test_clr();
    test_mid_reset();
    test_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
